loss_unit: RTL and testbench

//  Downstream end of the perceptron forward/backward protocol: consumes neuron results,

---
 rtl/loss_unit.sv | 151 +++++++++++++++
 tb/tb_loss_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loss_unit.sv
// loss_unit: downstream end of the perceptron forward/backward protocol.
// Buffers targets in a small FIFO, pairs each neuron result with the oldest
// queued target, and presents the signed error (target - result) on a
// valid/ready error port.
//
// Parameters:
//   W      result/target width (unsigned)
//   DEPTH  target FIFO entries (power of 2, >= 2)
//   CW     statistics counter width (LOSS_STATS_EN only)
//
// Ports:
//   clock, reset                      clock; asynchronous active-low reset
//   train                             1: issue errors, 0: consume results silently
//   target_valid/ready/data           target push handshake
//   result_valid/ready/data           neuron result handshake (pops a target)
//   error_valid/ready/data            signed 2W-bit error handshake
//   stats_clear, stats_miss/abs       statistics (only when LOSS_STATS_EN is defined)
//
// Optional feature macro: LOSS_STATS_EN (miss count and sum of |error|).
module loss_unit #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           train,
  input  logic           target_valid,
  output logic           target_ready,
  input  logic [W-1:0]   target_data,
  input  logic           result_valid,
  output logic           result_ready,
  input  logic [W-1:0]   result_data,
  output logic           error_valid,
  input  logic           error_ready,
  output logic [2*W-1:0] error_data
`ifdef LOSS_STATS_EN
  ,
  input  logic           stats_clear,
  output logic [CW-1:0]  stats_miss,
  output logic [CW-1:0]  stats_abs
`endif
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  // Target FIFO
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            empty, full;
  logic            target_hs, result_hs;
  logic [W-1:0]    head;

  assign empty        = (count == '0);
  assign full         = (count == CNTW'(DEPTH));
  assign target_ready = !full;
  assign head         = mem[rd_ptr];

  // Error register FSM
  logic [0:0]     state_q, state_d;
  logic [2*W-1:0] error_q, error_d;

  // A held error that is not being accepted blocks new results whatever the
  // value of train, so a stalled error is never overtaken.
  assign result_ready = !empty && ((state_q == StEmpty) || error_ready);
  assign target_hs    = target_valid && target_ready;
  assign result_hs    = result_valid && result_ready;
  assign error_valid  = (state_q == StHold);
  assign error_data   = error_q;

  // Operands are zero-extended by one bit, so the difference never overflows.
  logic signed [W:0] diff;
  logic [W-1:0]      abs_val;

  assign diff    = $signed({1'b0, head}) - $signed({1'b0, result_data});
  assign abs_val = diff[W] ? W'(-diff) : diff[W-1:0];

  always_ff @(posedge clock) begin
    if (target_hs) begin
      mem[wr_ptr] <= target_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (target_hs) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (result_hs) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({target_hs, result_hs})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    if (result_hs && train) begin
      state_d = StHold;
      error_d = {{(W-1){diff[W]}}, diff};
    end else if (error_valid && error_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

`ifdef LOSS_STATS_EN
  logic [CW:0] abs_sum;

  assign abs_sum = {1'b0, stats_abs} + (CW+1)'(abs_val);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stats_miss <= '0;
      stats_abs  <= '0;
    end else if (stats_clear) begin
      stats_miss <= '0;
      stats_abs  <= '0;
    end else if (result_hs) begin
      if ((diff != '0) && (stats_miss != '1)) begin
        stats_miss <= stats_miss + CW'(1);
      end
      stats_abs <= abs_sum[CW] ? '1 : abs_sum[CW-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_loss_unit.sv
// Directed testbench for loss_unit (W=8, DEPTH=4). Inputs change on the
// falling clock edge; outputs are sampled on the falling edge or #1 after it.
module tb_loss_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        train;
  logic        target_valid;
  logic        target_ready;
  logic [7:0]  target_data;
  logic        result_valid;
  logic        result_ready;
  logic [7:0]  result_data;
  logic        error_valid;
  logic        error_ready;
  logic [15:0] error_data;
`ifdef LOSS_STATS_EN
  logic        stats_clear;
  logic [15:0] stats_miss;
  logic [15:0] stats_abs;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  and_tgt [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
  logic [7:0]  and_res [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
  logic [15:0] and_exp [4] = '{16'h0000, 16'hFF01, 16'h0000, 16'h00FF};

  loss_unit #(.W(8), .DEPTH(4), .CW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .train        (train),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .target_data  (target_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .error_valid  (error_valid),
    .error_ready  (error_ready),
    .error_data   (error_data)
`ifdef LOSS_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .stats_miss   (stats_miss),
    .stats_abs    (stats_abs)
`endif
  );

  always #5 clock = ~clock;

  // One-cycle target push; caller knows the FIFO has room.
  task automatic push_target(input logic [7:0] d);
    target_valid = 1'b1;
    target_data  = d;
    @(negedge clock);
    target_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL reset_target_ready: got %b want 1", target_ready); end
    total++; if (result_ready !== 1'b0) begin bad++; $display("FAIL reset_result_ready: got %b want 0", result_ready); end
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL reset_error_valid: got %b want 0", error_valid); end
    total++; if (error_data !== 16'h0000) begin bad++; $display("FAIL reset_error_data: got %h want 0000", error_data); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_and_set;
    train       = 1'b1;
    error_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_target(and_tgt[i]);
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL and_full: got %b want 0", target_ready); end
    for (int k = 0; k < 4; k++) begin
      result_valid = 1'b1;
      result_data  = and_res[k];
      #1;
      total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL and_ready%0d: got %b want 1", k, result_ready); end
      @(negedge clock);
      total++; if (error_valid !== 1'b1) begin bad++; $display("FAIL and_valid%0d: got %b want 1", k, error_valid); end
      total++; if (error_data !== and_exp[k]) begin bad++; $display("FAIL and_data%0d: got %h want %h", k, error_data, and_exp[k]); end
    end
    result_valid = 1'b0;
    @(negedge clock);
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL and_drain: got %b want 0", error_valid); end
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL and_not_full: got %b want 1", target_ready); end
  endtask

  task automatic test_backpressure;
    train       = 1'b1;
    error_ready = 1'b0;
    push_target(8'hFF);
    push_target(8'h00);
    result_valid = 1'b1;
    result_data  = 8'h00;
    #1;
    total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready: got %b want 1", result_ready); end
    @(negedge clock);
    result_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (result_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready%0d: got %b want 0", i, result_ready); end
      total++; if (error_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid%0d: got %b want 1", i, error_valid); end
      total++; if (error_data !== 16'h00FF) begin bad++; $display("FAIL bp_stall_data%0d: got %h want 00ff", i, error_data); end
      @(negedge clock);
    end
    error_ready = 1'b1;
    #1;
    total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", result_ready); end
    @(negedge clock);
    result_valid = 1'b0;
    total++; if (error_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %b want 1", error_valid); end
    total++; if (error_data !== 16'hFFFF) begin bad++; $display("FAIL bp_second_data: got %h want ffff", error_data); end
    @(negedge clock);
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", error_valid); end
  endtask

  task automatic test_fifo_full;
    logic [15:0] exp_d;
    train       = 1'b1;
    error_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      target_valid = 1'b1;
      target_data  = 8'((i + 1) * 16);
      #1;
      total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL full_push%0d: got %b want 1", i, target_ready); end
      @(negedge clock);
    end
    target_data = 8'h50;
    #1;
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL full_fifth_blocked: got %b want 0", target_ready); end
    @(negedge clock);
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL full_still_blocked: got %b want 0", target_ready); end
    result_valid = 1'b1;
    result_data  = 8'h00;
    @(negedge clock);
    result_valid = 1'b0;
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop: got %b want 1", target_ready); end
    total++; if (error_data !== 16'h0010) begin bad++; $display("FAIL full_first_err: got %h want 0010", error_data); end
    @(negedge clock);
    target_valid = 1'b0;
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL full_refilled: got %b want 0", target_ready); end
    for (int k = 0; k < 4; k++) begin
      result_valid = 1'b1;
      result_data  = 8'h00;
      exp_d = 16'((k + 2) * 16);
      @(negedge clock);
      total++; if (error_data !== exp_d) begin bad++; $display("FAIL full_order%0d: got %h want %h", k, error_data, exp_d); end
    end
    result_valid = 1'b0;
    @(negedge clock);
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL full_drain: got %b want 0", error_valid); end
  endtask

  task automatic test_empty_fifo;
    result_valid = 1'b1;
    result_data  = 8'h05;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      total++; if (result_ready !== 1'b0 || error_valid !== 1'b0) begin
        bad++; $display("FAIL empty_stall%0d: got ready=%b valid=%b want 0 0", i, result_ready, error_valid);
      end
    end
    result_valid = 1'b0;
  endtask

  task automatic test_train_off;
    train       = 1'b0;
    error_ready = 1'b1;
`ifdef LOSS_STATS_EN
    stats_clear = 1'b1;
    @(negedge clock);
    stats_clear = 1'b0;
    total++; if (stats_miss !== 16'd0 || stats_abs !== 16'd0) begin
      bad++; $display("FAIL stats_clear: got %h %h want 0000 0000", stats_miss, stats_abs);
    end
`endif
    push_target(8'h80);
    result_valid = 1'b1;
    result_data  = 8'h00;
    #1;
    total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL noTrain_ready: got %b want 1", result_ready); end
    @(negedge clock);
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL noTrain_valid: got %b want 0", error_valid); end
    total++; if (error_data !== 16'h0050) begin bad++; $display("FAIL noTrain_data_held: got %h want 0050", error_data); end
    total++; if (result_ready !== 1'b0) begin bad++; $display("FAIL noTrain_popped: got %b want 0", result_ready); end
    result_valid = 1'b0;
`ifdef LOSS_STATS_EN
    total++; if (stats_miss !== 16'd1) begin bad++; $display("FAIL stats_miss: got %h want 0001", stats_miss); end
    total++; if (stats_abs !== 16'h0080) begin bad++; $display("FAIL stats_abs: got %h want 0080", stats_abs); end
    push_target(8'h01);
    result_valid = 1'b1;
    stats_clear  = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    stats_clear  = 1'b0;
    total++; if (stats_miss !== 16'd0 || stats_abs !== 16'd0) begin
      bad++; $display("FAIL stats_clear_wins: got %h %h want 0000 0000", stats_miss, stats_abs);
    end
`endif
    train = 1'b1;
  endtask

  task automatic test_reset_mid_hold;
    train       = 1'b1;
    error_ready = 1'b0;
    push_target(8'hFF);
    push_target(8'h11);
    result_valid = 1'b1;
    result_data  = 8'h00;
    @(negedge clock);
    result_valid = 1'b0;
    total++; if (error_valid !== 1'b1 || error_data !== 16'h00FF) begin
      bad++; $display("FAIL rst_hold: got %b %h want 1 00ff", error_valid, error_data);
    end
    reset = 1'b0;
    @(negedge clock);
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", error_valid); end
    total++; if (error_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", error_data); end
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL rst_target_ready: got %b want 1", target_ready); end
    total++; if (result_ready !== 1'b0) begin bad++; $display("FAIL rst_fifo_empty: got %b want 0", result_ready); end
    reset       = 1'b1;
    error_ready = 1'b1;
    @(negedge clock);
    push_target(8'hFF);
    result_valid = 1'b1;
    result_data  = 8'h00;
    #1;
    total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL rst_pair_ready: got %b want 1", result_ready); end
    @(negedge clock);
    result_valid = 1'b0;
    total++; if (error_valid !== 1'b1 || error_data !== 16'h00FF) begin
      bad++; $display("FAIL rst_pair: got %b %h want 1 00ff", error_valid, error_data);
    end
    @(negedge clock);
    total++; if (error_valid !== 1'b0 || result_ready !== 1'b0) begin
      bad++; $display("FAIL rst_pair_drain: got %b %b want 0 0", error_valid, result_ready);
    end
  endtask

  initial begin
    reset        = 1'b0;
    train        = 1'b1;
    target_valid = 1'b0;
    target_data  = 8'h00;
    result_valid = 1'b0;
    result_data  = 8'h00;
    error_ready  = 1'b1;
`ifdef LOSS_STATS_EN
    stats_clear  = 1'b0;
`endif
    test_reset;
    test_and_set;
    test_backpressure;
    test_fifo_full;
    test_empty_fifo;
    test_train_off;
    test_reset_mid_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
